// File: rtl/output_accum_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : output_buf_pkg
// Brief   : Shared FSM encodings and saturation limits for output_accum_buffer.
// Revision: 1.0 - initial release
// ============================================================================
package output_buf_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Limits are built at 64 bits and truncated by the caller to its width.
  function automatic logic signed [63:0] sat_max(input int w);
    sat_max = (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    sat_min = -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_accum_buffer_if.sv
`default_nettype none
// ============================================================================
// Module  : output_accum_buffer_if
// Brief   : Write, random-read and stream port bundle of output_accum_buffer.
// Revision: 1.0 - initial release
// ============================================================================
interface output_accum_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 2
);
  logic                         wr_en;
  logic                         wr_acc;
  logic [ADDR_BITS-1:0]         wr_addr;
  logic signed [DATA_WIDTH-1:0] wr_data;
  logic                         clear;
  logic [ADDR_BITS-1:0]         rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         strm_start;
  logic                         m_valid;
  logic                         m_ready;
  logic signed [DATA_WIDTH-1:0] m_data;
  logic                         m_last;
  logic                         busy;
  logic                         sat_flag;

  modport master (
    output wr_en, wr_acc, wr_addr, wr_data, clear, rd_addr, strm_start, m_ready,
    input  rd_data, m_valid, m_data, m_last, busy, sat_flag
  );

  modport slave (
    input  wr_en, wr_acc, wr_addr, wr_data, clear, rd_addr, strm_start, m_ready,
    output rd_data, m_valid, m_data, m_last, busy, sat_flag
  );
endinterface
`default_nettype wire

// File: rtl/output_accum_buffer_sat_add.sv
`default_nettype none
// ============================================================================
// Module  : sat_add_signed
// Brief   : Combinational signed add clamped to the W-bit range, with flag.
// Revision: 1.0 - initial release
// ============================================================================
module sat_add_signed
  import output_buf_pkg::*;
#(
  parameter int W = 32
) (
  input  wire logic signed [W-1:0] i_a,
  input  wire logic signed [W-1:0] i_b,
  output logic signed [W-1:0]      o_sum,
  output logic                     o_sat
);
  localparam logic signed [W-1:0] c_SAT_MAX = W'(sat_max(W));
  localparam logic signed [W-1:0] c_SAT_MIN = W'(sat_min(W));

  logic signed [W:0] w_wide;

  assign w_wide = $signed({i_a[W-1], i_a}) + $signed({i_b[W-1], i_b});
  // Overflow iff the extra sign bit disagrees with the W-bit sign.
  assign o_sat  = w_wide[W] ^ w_wide[W-1];
  assign o_sum  = !o_sat ? w_wide[W-1:0] : (w_wide[W] ? c_SAT_MIN : c_SAT_MAX);
endmodule
`default_nettype wire

// File: rtl/output_accum_buffer.sv
`default_nettype none
// ============================================================================
// Module  : output_accum_buffer
// Brief   : DEPTH x DATA_WIDTH signed store with overwrite/saturating-accumulate
//           writes, random read and in-order valid/ready streaming.
//           OUTPUT_ACCUM_BUFFER_RDREG_EN registers rd_data and m_data.
// Revision: 1.0 - initial release
// ============================================================================
module output_accum_buffer
  import output_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 2
) (
  input wire logic              clk,
  input wire logic              reset,
  output_accum_buffer_if.slave  bus
);
  localparam int                   c_DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] c_LAST_IDX = ADDR_BITS'(c_DEPTH - 1);

  logic signed [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic                         r_sat_flag;
  state_t                       r_state;
  logic [ADDR_BITS-1:0]         r_idx;
  logic signed [DATA_WIDTH-1:0] w_acc_sum;
  logic                         w_acc_sat;

  sat_add_signed #(.W(DATA_WIDTH)) u_sat_add (
    .i_a   (r_mem[bus.wr_addr]),
    .i_b   (bus.wr_data),
    .o_sum (w_acc_sum),
    .o_sat (w_acc_sat)
  );

  // Register array so clear can zero every entry in a single cycle.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
      r_sat_flag <= 1'b0;
    end else if (bus.wr_en) begin
      if (bus.wr_acc) begin
        r_mem[bus.wr_addr] <= w_acc_sum;
        if (w_acc_sat) r_sat_flag <= 1'b1;
      end else begin
        r_mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  assign bus.sat_flag = r_sat_flag;
  assign bus.busy     = (r_state == ST_STREAM);

`ifdef OUTPUT_ACCUM_BUFFER_RDREG_EN
  logic                         r_fetch_done;
  logic                         r_m_valid;
  logic                         r_m_last;
  logic signed [DATA_WIDTH-1:0] r_m_data;
  logic signed [DATA_WIDTH-1:0] r_rd_data;
  logic                         w_load;

  // r_idx is the fetch pointer; it runs one beat ahead of the output register.
  assign w_load = (r_state == ST_STREAM) && !r_fetch_done && (!r_m_valid || bus.m_ready);

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_fetch_done <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      if (reset) r_m_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.strm_start) begin
            r_state      <= ST_STREAM;
            r_idx        <= '0;
            r_fetch_done <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_mem[r_idx];
            r_m_last  <= (r_idx == c_LAST_IDX);
            if (r_idx == c_LAST_IDX) r_fetch_done <= 1'b1;
            else                     r_idx        <= r_idx + 1'b1;
          end else if (r_m_valid && bus.m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_mem[bus.rd_addr];
  end

  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_last  = r_m_last;
  assign bus.rd_data = r_rd_data;
`else
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.strm_start) begin
            r_state <= ST_STREAM;
            r_idx   <= '0;
          end
        end
        ST_STREAM: begin
          if (bus.m_ready) begin
            if (r_idx == c_LAST_IDX) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_valid = (r_state == ST_STREAM);
  assign bus.m_data  = r_mem[r_idx];
  assign bus.m_last  = (r_state == ST_STREAM) && (r_idx == c_LAST_IDX);
  assign bus.rd_data = r_mem[bus.rd_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_accum_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_output_accum_buffer
// Brief   : Directed scoreboard bench for output_accum_buffer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_output_accum_buffer;
  localparam int DW = 32;
  localparam int AB = 2;
`ifdef OUTPUT_ACCUM_BUFFER_RDREG_EN
  localparam int c_RDLAT = 1;
`else
  localparam int c_RDLAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_accum_buffer_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  output_accum_buffer #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  int          pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat {last, data} expectations are consumed here as the DUT hands them over.
  always @(negedge clk) begin
    if (!reset && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h last %b expected no beat", bus.m_data, bus.m_last);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", bus.m_data, mon_e[DW-1:0]);
        check("beat_last", {31'b0, bus.m_last}, {31'b0, mon_e[DW]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [DW-1:0] d, input logic acc);
    bus.wr_en   = 1'b1;
    bus.wr_acc  = acc;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_acc  = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [AB-1:0] a, input logic [DW-1:0] exp);
    bus.rd_addr = a;
    if (c_RDLAT != 0) tick();
    #2;
    check(name, bus.rd_data, exp);
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 60) begin
      tick();
      n++;
    end
    check("stream_done_busy", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic fill4(input logic [DW-1:0] d0, d1, d2, d3);
    wr(2'd0, d0, 1'b0);
    wr(2'd1, d1, 1'b0);
    wr(2'd2, d2, 1'b0);
    wr(2'd3, d3, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 0; bus.wr_acc = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clear = 0; bus.rd_addr = '0; bus.strm_start = 0; bus.m_ready = 0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_sat_flag", {31'b0, bus.sat_flag}, 32'd0);
    check("rst_m_valid",  {31'b0, bus.m_valid},  32'd0);
    check("rst_busy",     {31'b0, bus.busy},     32'd0);
    check("rst_m_last",   {31'b0, bus.m_last},   32'd0);
    for (int a = 0; a < 4; a++) read_chk("rst_rd", AB'(a), 32'd0);

    // Overwrite, accumulate, saturate both directions
    wr(2'd0, 32'd5, 1'b0);
    wr(2'd0, -32'sd3, 1'b1);
    read_chk("acc_5m3", 2'd0, 32'd2);
    check("no_sat_yet", {31'b0, bus.sat_flag}, 32'd0);
    wr(2'd1, 32'd1, 1'b0);
    wr(2'd1, 32'h7FFF_FFFF, 1'b1);
    read_chk("sat_pos", 2'd1, 32'h7FFF_FFFF);
    check("sat_flag_set", {31'b0, bus.sat_flag}, 32'd1);
    wr(2'd2, 32'h8000_0000, 1'b0);
    wr(2'd2, 32'hFFFF_FFFF, 1'b1);
    read_chk("sat_neg", 2'd2, 32'h8000_0000);

    // Plain stream with m_ready held high
    fill4(32'd10, 32'd20, 32'd30, 32'd40);
    push_beat(32'd10, 0); push_beat(32'd20, 0); push_beat(32'd30, 0); push_beat(32'd40, 1);
    bus.m_ready = 1'b1;
    bus.strm_start = 1'b1;
    tick();
    bus.strm_start = 1'b0;
    check("first_valid_t3", {31'b0, bus.m_valid}, (c_RDLAT == 0) ? 32'd1 : 32'd0);
    wait_idle();
    check("t3_m_valid_end", {31'b0, bus.m_valid}, 32'd0);
    check("t3_q_drained", 32'(exp_q.size()), 32'd0);

    // Stalling consumer, with a stray strm_start mid-stream
    fill4(32'd1, 32'd2, 32'd3, 32'd4);
    push_beat(32'd1, 0); push_beat(32'd2, 0); push_beat(32'd3, 0); push_beat(32'd4, 1);
    for (int k = 0; k < 60; k++) begin
      bus.m_ready    = pat[k % 8] != 0;
      bus.strm_start = (k == 0) || (k == 3);
      tick();
      if (k > 0 && !bus.busy) break;
    end
    bus.strm_start = 1'b0;
    bus.m_ready    = 1'b1;
    check("t4_busy_end", {31'b0, bus.busy}, 32'd0);
    repeat (3) tick();
    check("t4_q_drained", 32'(exp_q.size()), 32'd0);
    check("t4_no_restart", {31'b0, bus.busy}, 32'd0);

    // Clear during beat 2 with a colliding write
    wr(2'd0, 32'h7FFF_FFFF, 1'b0);
    wr(2'd0, 32'd1, 1'b1);
    fill4(32'd5, 32'd6, 32'd7, 32'd8);
    check("t5_sat_before", {31'b0, bus.sat_flag}, 32'd1);
    push_beat(32'd5, 0); push_beat(32'd6, 0);
    bus.m_ready = 1'b1;
    bus.strm_start = 1'b1;
    tick();
    bus.strm_start = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    check("t5_two_beats", 32'(exp_q.size()), 32'd0);
    bus.m_ready = 1'b0;
    bus.clear   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 32'd99;
    tick();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    check("t5_valid_drop", {31'b0, bus.m_valid}, 32'd0);
    check("t5_busy_drop",  {31'b0, bus.busy},    32'd0);
    check("t5_sat_clear",  {31'b0, bus.sat_flag}, 32'd0);
    for (int a = 0; a < 4; a++) read_chk("t5_cleared", AB'(a), 32'd0);
    bus.m_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-stream
    fill4(32'd1, 32'd2, 32'd3, 32'd4);
    bus.m_ready = 1'b0;
    bus.strm_start = 1'b1;
    tick();
    bus.strm_start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_valid_rst", {31'b0, bus.m_valid}, 32'd0);
    check("t6_busy_rst",  {31'b0, bus.busy},    32'd0);
    read_chk("t6_rd_rst", 2'd2, 32'd0);
    bus.m_ready = 1'b1;
    repeat (3) tick();

    // Re-run of the plain stream, then a back-to-back second stream
    fill4(32'd10, 32'd20, 32'd30, 32'd40);
    for (int r = 0; r < 2; r++) begin
      push_beat(32'd10, 0); push_beat(32'd20, 0); push_beat(32'd30, 0); push_beat(32'd40, 1);
    end
    bus.strm_start = 1'b1;
    tick();
    bus.strm_start = 1'b0;
    check("first_valid_t6", {31'b0, bus.m_valid}, (c_RDLAT == 0) ? 32'd1 : 32'd0);
    wait_idle();
    bus.strm_start = 1'b1;
    tick();
    bus.strm_start = 1'b0;
    check("b2b_busy", {31'b0, bus.busy}, 32'd1);
    wait_idle();
    repeat (2) tick();
    check("final_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
